// File: rtl/seq_alu_if.sv
// Request/response bundle between operand muxing and the sequential ALU.
// Dbg_State mirrors the ALU FSM (0 = IDLE, 1 = SHIFT) for checkers.
interface seq_alu_if #(
  parameter int XLEN = 32
);
  // Handshake: a request is taken on a rising edge where Start=1 and Busy=0.
  // Done pulses for exactly one cycle; Result/Branch_Taken/Illegal are valid
  // then and hold until the following Done. A Start in the Done cycle is taken.
  logic            Start;
  logic [2:0]      ALU_Ctrl;
  logic            Sub;
  logic [2:0]      Funct3;
  logic            Funct7_5;
  logic [XLEN-1:0] Op_A;
  logic [XLEN-1:0] Op_B;
  logic [XLEN-1:0] Result;
  logic            Branch_Taken;
  logic            Illegal;
  logic            Busy;
  logic            Done;
  logic            Dbg_State;

  modport master (
    output Start, ALU_Ctrl, Sub, Funct3, Funct7_5, Op_A, Op_B,
    input  Result, Branch_Taken, Illegal, Busy, Done, Dbg_State
  );

  modport slave (
    input  Start, ALU_Ctrl, Sub, Funct3, Funct7_5, Op_A, Op_B,
    output Result, Branch_Taken, Illegal, Busy, Done, Dbg_State
  );
endinterface

// File: rtl/seq_alu.sv
// RV32I execution-stage ALU with registered result and Start/Done handshake.
// Define SEQ_ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; default shifts one bit per cycle.
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic     CLK,
  input  logic     RST,
  seq_alu_if.slave bus
);

  logic [XLEN-1:0] result_q;
  logic            br_q;
  logic            ill_q;
  logic            done_q;

  logic [XLEN-1:0] res_d;
  logic            br_d;
  logic            ill_d;
  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] diff;

  assign shamt = bus.Op_B[4:0];
  assign lt_s  = $signed(bus.Op_A) < $signed(bus.Op_B);
  assign lt_u  = bus.Op_A < bus.Op_B;
  assign diff  = bus.Op_A - bus.Op_B;

`ifndef SEQ_ALU_FAST_SHIFT_EN
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q;
  logic            busy_q;
  logic [XLEN-1:0] work_q;
  logic [4:0]      cnt_q;
  logic            left_q;
  logic            arith_q;
  logic [XLEN-1:0] work_step;
  logic            shift_go_d;

  // sra feeds the sign bit back in; srl feeds zero.
  assign work_step = left_q ? {work_q[XLEN-2:0], 1'b0}
                            : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
`endif

  always_comb begin
    res_d = '0;
    br_d  = 1'b0;
    ill_d = 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
    shift_go_d = 1'b0;
`endif
    case (bus.ALU_Ctrl)
      3'b000: res_d = bus.Sub ? diff : (bus.Op_A + bus.Op_B);
      3'b001: begin
        case (bus.Funct3)
          3'b010:  res_d = {{(XLEN-1){1'b0}}, lt_s};
          3'b011:  res_d = {{(XLEN-1){1'b0}}, lt_u};
          default: ill_d = 1'b1;
        endcase
      end
      3'b010: begin
        case (bus.Funct3)
          3'b100:  res_d = bus.Op_A ^ bus.Op_B;
          3'b110:  res_d = bus.Op_A | bus.Op_B;
          3'b111:  res_d = bus.Op_A & bus.Op_B;
          default: ill_d = 1'b1;
        endcase
      end
      3'b011: begin
        case (bus.Funct3)
`ifdef SEQ_ALU_FAST_SHIFT_EN
          3'b001:  res_d = bus.Op_A << shamt;
          3'b101:  res_d = bus.Funct7_5 ? XLEN'($signed(bus.Op_A) >>> shamt)
                                        : (bus.Op_A >> shamt);
`else
          // A zero shift completes at once with the operand unchanged.
          3'b001, 3'b101: begin
            res_d      = bus.Op_A;
            shift_go_d = (shamt != 5'd0);
          end
`endif
          default: ill_d = 1'b1;
        endcase
      end
      3'b100: begin
        res_d = diff;
        case (bus.Funct3)
          3'b000:  br_d = (bus.Op_A == bus.Op_B);
          3'b001:  br_d = (bus.Op_A != bus.Op_B);
          3'b100:  br_d = lt_s;
          3'b101:  br_d = !lt_s;
          3'b110:  br_d = lt_u;
          3'b111:  br_d = !lt_u;
          default: ill_d = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      res_d = '0;
      br_d  = 1'b0;
    end
  end

`ifdef SEQ_ALU_FAST_SHIFT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_q <= '0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= bus.Start;
      if (bus.Start) begin
        result_q <= res_d;
        br_q     <= br_d;
        ill_q    <= ill_d;
      end
    end
  end

  assign bus.Busy      = 1'b0;
  assign bus.Dbg_State = 1'b0;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      result_q <= '0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      work_q   <= '0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            if (shift_go_d) begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
              work_q  <= bus.Op_A;
              cnt_q   <= shamt;
              left_q  <= (bus.Funct3 == 3'b001);
              arith_q <= bus.Funct7_5;
            end else begin
              result_q <= res_d;
              br_q     <= br_d;
              ill_q    <= ill_d;
              done_q   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work_q <= work_step;
          cnt_q  <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= work_step;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Dbg_State = (state_q == SHIFT);
`endif

  assign bus.Result       = result_q;
  assign bus.Branch_Taken = br_q;
  assign bus.Illegal      = ill_q;
  assign bus.Done         = done_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Execution-stage ALU that consumes the 3-bit `ALU_Ctrl` / `Sub` encoding produced by the ALU control decoder, together with `Funct3`/`Funct7_5`, and returns a registered result with a start/done handshake. Add/sub, compare, logic and branch evaluation finish in one cycle. Shifts run iteratively, one bit per cycle, unless the barrel-shift option is compiled in. The block sits between operand muxing and the writeback/branch-resolution logic of the RV32I core.

## Interface
- `XLEN`, 32, operand/result width (shift amount is always `Op_B[4:0]`)
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `Start`  in  1  request; sampled only while `Busy`=0
- `ALU_Ctrl`  in  3  000 add/sub, 001 set-less-than, 010 logic, 011 shift, 100 branch compare, 111 no-op/illegal
- `Sub`  in  1  subtract select for code 000
- `Funct3`  in  3  operation detail for codes 001/010/011/100
- `Funct7_5`  in  1  arithmetic right shift when set (code 011, Funct3=101)
- `Op_A`, `Op_B`  in  XLEN  operands
- `Result`  out  XLEN  registered result, held until the next `Done`
- `Branch_Taken`  out  1  registered branch outcome; 0 for non-branch codes
- `Illegal`  out  1  registered; set with `Done` for unsupported encodings
- `Busy`  out  1  iterative shift in progress
- `Done`  out  1  one-cycle pulse; `Result`/`Branch_Taken`/`Illegal` are valid in this cycle

## Operation
- States: IDLE, SHIFT. A `Start` in IDLE captures all inputs.
- 000: `Op_A + Op_B`, or `Op_A - Op_B` if `Sub`. Wrap modulo 2^XLEN, no flags.
- 001: Funct3 010 signed `A<B`, 011 unsigned `A<B`. Result is 0 or 1 zero-extended. Other Funct3 values are Illegal.
- 010: Funct3 100 xor, 110 or, 111 and. Other Funct3 values are Illegal.
- 011: Funct3 001 sll, 101 srl (`Funct7_5`=0) or sra (`Funct7_5`=1). Other Funct3 values are Illegal. `Sub` is ignored.
- 100: Funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu set `Branch_Taken`. `Result` = `Op_A - Op_B`. Funct3 010/011 are Illegal.
- 101, 110, 111: Illegal.
- Any Illegal case: `Result`=0, `Branch_Taken`=0, `Illegal`=1. `Done` still pulses.
- Shift with shamt=k>0: go to SHIFT with a working register = `Op_A` and a count = k. Each cycle shift by one bit (sra replicates the MSB) and decrement the count. At count 0 return to IDLE and pulse `Done`.

## Timing
- Reset (async assert, sync release): IDLE; `Result`=0; `Branch_Taken`=0; `Illegal`=0; `Busy`=0; `Done`=0.
- `Start` sampled in cycle 0:
  - Non-shift op, or shift with k=0: `Done`=1 in cycle 1; `Busy` never rises.
  - Shift with k>0: `Busy`=1 in cycles 1..k; `Done`=1 and `Busy`=0 in cycle k+1.
- `Start` while `Busy`=1 is ignored, with no effect on state or outputs.
- `Start` in the `Done` cycle is accepted (back-to-back). Throughput is 1 op/cycle for non-shift ops.
- `Result`, `Branch_Taken` and `Illegal` change only on a `Done` cycle or on reset.
- `RST` mid-shift aborts immediately to reset values; no `Done` is produced.
- Operand inputs may change freely after the `Start` cycle.

## Configuration
- `SEQ_ALU_FAST_SHIFT_EN` defined: single-cycle barrel shifter. Every op, shifts included, gives `Done` in cycle 1; the SHIFT state is not built; `Busy` is tied to 0.
- Not defined: iterative shifter as described above. This is the default, smaller-area build.

## Test plan
- Reset mid-shift: sll with k=20 started, `RST` pulsed in cycle 5 -> all outputs 0, IDLE, and no `Done` follows.
- Add/sub: `ALU_Ctrl`=000, `Sub`=1, A=5, B=7 -> `Done` in cycle 1, `Result`=0xFFFFFFFE, `Illegal`=0.
- Compare: `ALU_Ctrl`=001, Funct3=010, A=0xFFFFFFFF, B=1 -> `Result`=1. Same operands with Funct3=011 -> `Result`=0.
- Iterative sra:
  - Setup: `ALU_Ctrl`=011, Funct3=101, `Funct7_5`=1, A=0x80000000, B=31.
  - Expected: `Busy` high for cycles 1..31; `Done` in cycle 32 with `Result`=0xFFFFFFFF.
  - A `Start` issued in cycle 10 is ignored.
- Branch plus back-to-back: bltu with A=3, B=0xFFFFFFF0 -> `Branch_Taken`=1. A new `Start` in the `Done` cycle with `ALU_Ctrl`=111 -> `Done` next cycle with `Illegal`=1, `Result`=0, `Branch_Taken`=0.
- With `SEQ_ALU_FAST_SHIFT_EN`: sll with A=1, B=31 -> `Done` in cycle 1, `Result`=0x80000000, `Busy` never asserted.
